// File: rtl/uart_flash_bridge.sv
// uart_flash_bridge
// Parses framed commands from the UART byte interface and runs flash read or
// write bursts with an auto-incrementing address.
//   Frame: OP (0x52 read / 0x57 write), ADDR_W/8 address bytes MSB first,
//          LEN (1..MAX_BURST), then LEN data bytes for a write.
//   Replies: read data bytes, 0x06 (ACK) after a write, 0x15 (NAK) on error.
// Ports:
//   CLK_50MHZ, RST (async, active low)
//   UART side : RS_FLOW, RS_TRG_READ, RS_TRG_WRITE, RS_DATAIN (out),
//               RS_DATAOUT, RS_DONE (in)
//   Flash side: FL_ADDR, FL_WDATA, FL_FLOW, FL_TRG (out), FL_RDATA, FL_STATUS (in)
//   BUSY      : high whenever the FSM is not in IDLE
// Optional macro UART_FLASH_BRIDGE_TIMEOUT_EN: inter-byte timeout that turns a
// stalled frame into a NAK after TIMEOUT_CYCLES clocks.
module uart_flash_bridge #(
    parameter int ADDR_W         = 16,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    output logic              RS_FLOW,
    output logic              RS_TRG_READ,
    output logic              RS_TRG_WRITE,
    output logic [7:0]        RS_DATAIN,
    input  logic [7:0]        RS_DATAOUT,
    input  logic              RS_DONE,
    output logic [ADDR_W-1:0] FL_ADDR,
    output logic [7:0]        FL_WDATA,
    input  logic [7:0]        FL_RDATA,
    output logic              FL_FLOW,
    output logic              FL_TRG,
    input  logic              FL_STATUS,
    output logic              BUSY
);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_OP, S_GET_ADDR, S_GET_LEN, S_GET_DATA,
        S_FL_ACC, S_FL_WAIT, S_SEND, S_ACK, S_NAK
    } state_t;

    localparam logic [1:0] ADDR_BYTES = 2'(ADDR_W / 8);
    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] CODE_ACK   = 8'h06;
    localparam logic [7:0] CODE_NAK   = 8'h15;

    state_t            state_r, state_s;
    logic [7:0]        rem_r, rem_s;
    logic [1:0]        cnt_r, cnt_s;
    logic [ADDR_W-1:0] addr_s;
    logic              rs_flow_s, rs_rd_s, rs_wr_s, fl_flow_s, fl_trg_s;
    logic [7:0]        rs_din_s, fl_wdata_s;
    logic              rs_ok_s;
    logic              tmo_abort_s;

    // A RS_DONE coinciding with our own trigger pulse cannot belong to it.
    assign rs_ok_s = RS_DONE && !RS_TRG_READ && !RS_TRG_WRITE;

`ifdef UART_FLASH_BRIDGE_TIMEOUT_EN
    localparam logic [25:0] TMO_LIM = 26'(TIMEOUT_CYCLES);
    logic [25:0] tmo_r;

    // Inter-byte cycle counter; restarts on every byte and at frame start.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            tmo_r <= 26'd0;
        end else if (RS_DONE || (state_r == S_IDLE)) begin
            tmo_r <= 26'd0;
        end else if (tmo_r != {26{1'b1}}) begin
            tmo_r <= tmo_r + 26'd1;
        end else begin
            tmo_r <= tmo_r;
        end
    end

    assign tmo_abort_s = (tmo_r >= TMO_LIM);
`else
    assign tmo_abort_s = 1'b0;
`endif

    // Next-state and next-output logic; trigger pulses are issued on the
    // transition into the state that waits for the matching completion.
    always_comb begin
        state_s    = state_r;
        rem_s      = rem_r;
        cnt_s      = cnt_r;
        addr_s     = FL_ADDR;
        rs_flow_s  = RS_FLOW;
        rs_rd_s    = 1'b0;
        rs_wr_s    = 1'b0;
        rs_din_s   = RS_DATAIN;
        fl_wdata_s = FL_WDATA;
        fl_flow_s  = FL_FLOW;
        fl_trg_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                state_s   = S_GET_OP;
                rs_rd_s   = 1'b1;
                rs_flow_s = 1'b0;
            end
            S_GET_OP: begin
                if (rs_ok_s && ((RS_DATAOUT == OP_READ) || (RS_DATAOUT == OP_WRITE))) begin
                    state_s   = S_GET_ADDR;
                    cnt_s     = ADDR_BYTES;
                    fl_flow_s = (RS_DATAOUT == OP_WRITE);
                    rs_rd_s   = 1'b1;
                end else if (rs_ok_s) begin
                    state_s   = S_NAK;
                    rs_wr_s   = 1'b1;
                    rs_flow_s = 1'b1;
                    rs_din_s  = CODE_NAK;
                end else begin
                    state_s = state_r;
                end
            end
            S_GET_ADDR: begin
                if (rs_ok_s) begin
                    addr_s  = (FL_ADDR << 8) | ADDR_W'(RS_DATAOUT);
                    cnt_s   = cnt_r - 2'd1;
                    rs_rd_s = 1'b1;
                    state_s = (cnt_r == 2'd1) ? S_GET_LEN : S_GET_ADDR;
                end else if (tmo_abort_s) begin
                    state_s   = S_NAK;
                    rs_wr_s   = 1'b1;
                    rs_flow_s = 1'b1;
                    rs_din_s  = CODE_NAK;
                end else begin
                    state_s = state_r;
                end
            end
            S_GET_LEN: begin
                if (rs_ok_s && ((RS_DATAOUT == 8'd0) || (RS_DATAOUT > 8'(MAX_BURST)))) begin
                    state_s   = S_NAK;
                    rs_wr_s   = 1'b1;
                    rs_flow_s = 1'b1;
                    rs_din_s  = CODE_NAK;
                end else if (rs_ok_s) begin
                    rem_s = RS_DATAOUT;
                    if (FL_FLOW) begin
                        state_s = S_GET_DATA;
                        rs_rd_s = 1'b1;
                    end else begin
                        state_s  = S_FL_ACC;
                        fl_trg_s = 1'b1;
                    end
                end else if (tmo_abort_s) begin
                    state_s   = S_NAK;
                    rs_wr_s   = 1'b1;
                    rs_flow_s = 1'b1;
                    rs_din_s  = CODE_NAK;
                end else begin
                    state_s = state_r;
                end
            end
            S_GET_DATA: begin
                if (rs_ok_s) begin
                    fl_wdata_s = RS_DATAOUT;
                    state_s    = S_FL_ACC;
                    fl_trg_s   = 1'b1;
                end else if (tmo_abort_s) begin
                    state_s   = S_NAK;
                    rs_wr_s   = 1'b1;
                    rs_flow_s = 1'b1;
                    rs_din_s  = CODE_NAK;
                end else begin
                    state_s = state_r;
                end
            end
            S_FL_ACC: begin
                state_s = S_FL_WAIT;
            end
            S_FL_WAIT: begin
                if (FL_STATUS) begin
                    addr_s = FL_ADDR + ADDR_W'(1);
                    rem_s  = rem_r - 8'd1;
                    if (!FL_FLOW) begin
                        state_s   = S_SEND;
                        rs_din_s  = FL_RDATA;
                        rs_wr_s   = 1'b1;
                        rs_flow_s = 1'b1;
                    end else if (rem_r > 8'd1) begin
                        state_s   = S_GET_DATA;
                        rs_rd_s   = 1'b1;
                        rs_flow_s = 1'b0;
                    end else begin
                        state_s   = S_ACK;
                        rs_din_s  = CODE_ACK;
                        rs_wr_s   = 1'b1;
                        rs_flow_s = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_SEND: begin
                if (rs_ok_s && (rem_r != 8'd0)) begin
                    state_s  = S_FL_ACC;
                    fl_trg_s = 1'b1;
                end else if (rs_ok_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            S_ACK, S_NAK: begin
                if (rs_ok_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_r      <= S_IDLE;
            rem_r        <= 8'd0;
            cnt_r        <= 2'd0;
            FL_ADDR      <= '0;
            RS_FLOW      <= 1'b0;
            RS_TRG_READ  <= 1'b0;
            RS_TRG_WRITE <= 1'b0;
            RS_DATAIN    <= 8'd0;
            FL_WDATA     <= 8'd0;
            FL_FLOW      <= 1'b0;
            FL_TRG       <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            state_r      <= state_s;
            rem_r        <= rem_s;
            cnt_r        <= cnt_s;
            FL_ADDR      <= addr_s;
            RS_FLOW      <= rs_flow_s;
            RS_TRG_READ  <= rs_rd_s;
            RS_TRG_WRITE <= rs_wr_s;
            RS_DATAIN    <= rs_din_s;
            FL_WDATA     <= fl_wdata_s;
            FL_FLOW      <= fl_flow_s;
            FL_TRG       <= fl_trg_s;
            BUSY         <= (state_s != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_flash_bridge.sv
// Directed bench for uart_flash_bridge with behavioural UART and flash models.
module tb_uart_flash_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RS_FLOW, RS_TRG_READ, RS_TRG_WRITE;
    logic [7:0]  RS_DATAIN;
    logic [7:0]  RS_DATAOUT = 8'h00;
    logic        RS_DONE = 1'b0;
    logic [15:0] FL_ADDR;
    logic [7:0]  FL_WDATA;
    logic [7:0]  FL_RDATA = 8'h00;
    logic        FL_FLOW, FL_TRG, BUSY;
    logic        FL_STATUS = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  rdq[$];
    logic [15:0] aq[$];
    logic        fq[$];
    logic [7:0]  wq[$];
    int          trg_cnt = 0;
    logic        idle_seen = 1'b0;

    uart_flash_bridge #(.ADDR_W(16), .MAX_BURST(16), .TIMEOUT_CYCLES(100)) dut (
        .CLK_50MHZ(clk), .RST(rst_n),
        .RS_FLOW(RS_FLOW), .RS_TRG_READ(RS_TRG_READ), .RS_TRG_WRITE(RS_TRG_WRITE),
        .RS_DATAIN(RS_DATAIN), .RS_DATAOUT(RS_DATAOUT), .RS_DONE(RS_DONE),
        .FL_ADDR(FL_ADDR), .FL_WDATA(FL_WDATA), .FL_RDATA(FL_RDATA),
        .FL_FLOW(FL_FLOW), .FL_TRG(FL_TRG), .FL_STATUS(FL_STATUS), .BUSY(BUSY)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] qa(input int i);
        return (i < aq.size()) ? aq[i] : 16'hDEAD;
    endfunction
    function automatic logic [7:0] qt(input int i);
        return (i < txq.size()) ? txq[i] : 8'hEE;
    endfunction
    function automatic logic [7:0] qw(input int i);
        return (i < wq.size()) ? wq[i] : 8'hEE;
    endfunction
    function automatic logic qf(input int i);
        return (i < fq.size()) ? fq[i] : 1'bx;
    endfunction

    task automatic clear_logs();
        rxq.delete(); txq.delete(); rdq.delete();
        aq.delete(); fq.delete(); wq.delete();
        trg_cnt = 0;
        idle_seen = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        int k = 0;
        while ((txq.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(txq.size()), 64'(n));
        repeat (10) @(negedge clk);
    endtask

    // UART model: 3-cycle completion, reads served from rxq when available.
    initial begin : uart_model
        int         cnt;
        logic [7:0] byte_v;
        logic       pend;
        cnt = 0; pend = 1'b0; byte_v = 8'h00;
        forever begin
            @(negedge clk);
            RS_DONE = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                pend = 1'b0;
            end else begin
                if (!BUSY) idle_seen = 1'b1;
                if (RS_TRG_READ) pend = 1'b1;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        RS_DONE = 1'b1;
                        RS_DATAOUT = byte_v;
                    end
                end else if (RS_TRG_WRITE) begin
                    txq.push_back(RS_DATAIN);
                    byte_v = 8'h00;
                    cnt = 3;
                end else if (pend && (rxq.size() > 0)) begin
                    byte_v = rxq.pop_front();
                    pend = 1'b0;
                    cnt = 3;
                end
            end
        end
    end

    // Flash model: logs every access, completes 2 cycles after FL_TRG.
    initial begin : flash_model
        int cnt;
        logic rd;
        cnt = 0; rd = 1'b0;
        forever begin
            @(negedge clk);
            FL_STATUS = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    FL_STATUS = 1'b1;
                    FL_RDATA = (rd && (rdq.size() > 0)) ? rdq.pop_front() : 8'h00;
                end
            end else if (FL_TRG) begin
                trg_cnt++;
                aq.push_back(FL_ADDR);
                fq.push_back(FL_FLOW);
                wq.push_back(FL_WDATA);
                rd = !FL_FLOW;
                cnt = 2;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "simulation hung");
    end

    initial begin : stim
        int k;
        repeat (3) @(negedge clk);
        check_eq("reset_outs",
                 {RS_FLOW, RS_TRG_READ, RS_TRG_WRITE, RS_DATAIN, FL_ADDR, FL_WDATA, FL_FLOW, FL_TRG, BUSY},
                 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("busy_after_reset", BUSY, 1'b1);

        // Read burst 0x0100..0x0102
        clear_logs();
        rdq = '{8'hAA, 8'hBB, 8'hCC};
        rxq = '{8'h52, 8'h01, 8'h00, 8'h03};
        wait_tx("rd_tx_cnt", 3, 500);
        check_eq("rd_trg_cnt", 64'(trg_cnt), 64'd3);
        check_eq("rd_addr0", qa(0), 16'h0100);
        check_eq("rd_addr1", qa(1), 16'h0101);
        check_eq("rd_addr2", qa(2), 16'h0102);
        check_eq("rd_flows", {qf(0), qf(1), qf(2)}, 3'b000);
        check_eq("rd_tx", {qt(0), qt(1), qt(2)}, 24'hAABBCC);
        check_eq("rd_busy_low_seen", idle_seen, 1'b1);

        // Write burst 0x0010..0x0011
        clear_logs();
        rxq = '{8'h57, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22};
        wait_tx("wr_tx_cnt", 1, 500);
        check_eq("wr_trg_cnt", 64'(trg_cnt), 64'd2);
        check_eq("wr_addrs", {qa(0), qa(1)}, 32'h0010_0011);
        check_eq("wr_flows", {qf(0), qf(1)}, 2'b11);
        check_eq("wr_data", {qw(0), qw(1)}, 16'h1122);
        check_eq("wr_ack", qt(0), 8'h06);

        // Bad opcode
        clear_logs();
        rxq = '{8'h41};
        wait_tx("badop_tx_cnt", 1, 200);
        check_eq("badop_nak", qt(0), 8'h15);
        check_eq("badop_trg", 64'(trg_cnt), 64'd0);

        // LEN = 0
        clear_logs();
        rxq = '{8'h52, 8'h00, 8'h00, 8'h00};
        wait_tx("len0_tx_cnt", 1, 200);
        check_eq("len0_nak", qt(0), 8'h15);
        check_eq("len0_trg", 64'(trg_cnt), 64'd0);

        // LEN = MAX_BURST + 1
        clear_logs();
        rxq = '{8'h52, 8'h00, 8'h00, 8'h11};
        wait_tx("len17_tx_cnt", 1, 200);
        check_eq("len17_nak", qt(0), 8'h15);
        check_eq("len17_trg", 64'(trg_cnt), 64'd0);

        // LEN = MAX_BURST is accepted
        clear_logs();
        for (int i = 0; i < 16; i++) rdq.push_back(8'(i));
        rxq = '{8'h52, 8'h02, 8'h00, 8'h10};
        wait_tx("len16_tx_cnt", 16, 1500);
        check_eq("len16_trg", 64'(trg_cnt), 64'd16);
        check_eq("len16_last_addr", qa(15), 16'h020F);
        check_eq("len16_tx_ends", {qt(0), qt(15)}, 16'h000F);

        // Address wrap
        clear_logs();
        rdq = '{8'h31, 8'h32};
        rxq = '{8'h52, 8'hFF, 8'hFF, 8'h02};
        wait_tx("wrap_tx_cnt", 2, 500);
        check_eq("wrap_addrs", {qa(0), qa(1)}, 32'hFFFF_0000);
        check_eq("wrap_tx", {qt(0), qt(1)}, 16'h3132);

        // Reset during FL_WAIT of a read
        clear_logs();
        rdq = '{8'h99};
        rxq = '{8'h52, 8'h12, 8'h34, 8'h01};
        k = 0;
        while ((trg_cnt < 1) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check_eq("rstmid_trg_seen", 64'(trg_cnt), 64'd1);
        @(posedge clk);
        #1;
        check_eq("rstmid_addr_before", FL_ADDR, 16'h1234);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_outs",
                 {RS_FLOW, RS_TRG_READ, RS_TRG_WRITE, RS_DATAIN, FL_ADDR, FL_WDATA, FL_FLOW, FL_TRG, BUSY},
                 64'd0);
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rstmid_no_reply", 64'(txq.size()), 64'd0);
        rdq = '{8'h5A};
        rxq = '{8'h52, 8'h00, 8'h00, 8'h01};
        wait_tx("after_rst_tx_cnt", 1, 300);
        check_eq("after_rst_addr", qa(0), 16'h0000);
        check_eq("after_rst_tx", qt(0), 8'h5A);

        // Stalled frame
        clear_logs();
        rxq = '{8'h57, 8'h00};
`ifdef UART_FLASH_BRIDGE_TIMEOUT_EN
        wait_tx("tmo_tx_cnt", 1, 300);
        check_eq("tmo_nak", qt(0), 8'h15);
        check_eq("tmo_trg", 64'(trg_cnt), 64'd0);
`else
        repeat (300) @(negedge clk);
        check_eq("stall_no_tx", 64'(txq.size()), 64'd0);
        check_eq("stall_busy", BUSY, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_flash_bridge.md
Name: uart_flash_bridge

Overview:
- Parametrised successor to the fixed 8-bit UART/flash manager. Parses framed commands arriving over the UART byte interface and performs flash reads and writes as bursts with auto-incrementing addresses.
- Returns read data or ACK/NAK bytes over UART.
- Sits between the UART and Flash blocks in the top level and replaces the single-byte manager.

Parameters:
- ADDR_W, 16, flash address width in bits; multiple of 8, range 8..24; sent as ADDR_W/8 bytes, MSB first.
- MAX_BURST, 16, maximum burst length in bytes, range 1..255.
- TIMEOUT_CYCLES, 50000000, inter-byte timeout in clock cycles; used only with the optional feature.

Ports:
- CLK_50MHZ  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- RS_FLOW  out  1  UART operation select: 0 = receive, 1 = transmit.
- RS_TRG_READ  out  1  one-cycle pulse requesting one received byte.
- RS_TRG_WRITE  out  1  one-cycle pulse starting transmission of RS_DATAIN.
- RS_DATAIN  out  8  byte to transmit.
- RS_DATAOUT  in  8  received byte; valid in the cycle RS_DONE is high after a read.
- RS_DONE  in  1  one-cycle pulse marking completion of the pending UART operation.
- FL_ADDR  out  ADDR_W  flash byte address.
- FL_WDATA  out  8  flash write data.
- FL_RDATA  in  8  flash read data; valid in the cycle FL_STATUS is high after a read.
- FL_FLOW  out  1  flash operation select: 0 = read, 1 = write.
- FL_TRG  out  1  one-cycle pulse starting a flash access.
- FL_STATUS  in  1  one-cycle pulse marking completion of the flash access.
- BUSY  out  1  high while any state other than IDLE is active.

Behaviour:
- Reset (RST low, asynchronous):
  - All outputs 0.
  - State = IDLE, all counters 0.
- Frame format: OP, ADDR bytes (ADDR_W/8), LEN, then LEN data bytes for a write only.
  - OP 0x52 = read; OP 0x57 = write.
  - LEN ranges 1..MAX_BURST.
- UART handshake:
  - Set RS_FLOW and RS_DATAIN, then pulse the trigger for exactly one cycle.
  - Hold RS_FLOW and RS_DATAIN stable until RS_DONE arrives.
  - Never issue a new trigger before RS_DONE.
- Flash handshake:
  - Same rule: FL_ADDR, FL_WDATA and FL_FLOW stable from the FL_TRG cycle until FL_STATUS.
  - Exactly one outstanding access at a time.
- States:
  - IDLE: pulse RS_TRG_READ, go to GET_OP.
  - GET_OP: on RS_DONE, latch opcode.
    - Valid opcode: go to GET_ADDR with byte counter = ADDR_W/8.
    - Otherwise: go to NAK.
  - GET_ADDR: request one byte per iteration and shift it into the address register (MSB first); after the last byte go to GET_LEN.
  - GET_LEN: on RS_DONE, latch LEN.
    - LEN=0 or LEN>MAX_BURST: go to NAK.
    - Read: go to FL_ACC.
    - Write: go to GET_DATA.
  - GET_DATA: request a byte; on RS_DONE set FL_WDATA, go to FL_ACC.
  - FL_ACC: pulse FL_TRG, go to FL_WAIT.
  - FL_WAIT: on FL_STATUS, address += 1 (wraps modulo 2^ADDR_W), remaining count -= 1.
    - Read: latch FL_RDATA, go to SEND.
    - Write: if remaining > 0 go to GET_DATA, else go to ACK.
  - SEND: transmit the latched byte; on RS_DONE, if remaining > 0 go to FL_ACC, else go to IDLE.
  - ACK: transmit 0x06; on RS_DONE go to IDLE.
  - NAK: transmit 0x15; on RS_DONE go to IDLE. Bytes already received in the frame are discarded; no flash access occurs.
- Latency:
  - FL_TRG is asserted 1 cycle after the RS_DONE of the last address/LEN byte (read) or of each data byte (write).
  - RS_TRG_WRITE is asserted 1 cycle after FL_STATUS on a read.
- Boundary conditions:
  - Address wrap: 2^ADDR_W-1 followed by 0 within the same burst; no error.
  - Unexpected RS_DONE or FL_STATUS while no operation is outstanding: ignored.
  - Reset mid-burst: aborts immediately; no ACK/NAK is sent.

Optional Feature:
- Macro: UART_FLASH_BRIDGE_TIMEOUT_EN.
- When defined:
  - A 26-bit cycle counter clears on every RS_DONE and on entry to GET_OP.
  - While in GET_ADDR, GET_LEN or GET_DATA waiting for a byte, reaching TIMEOUT_CYCLES abandons the frame and goes to NAK.
  - A write burst interrupted this way keeps the bytes already programmed.
- When not defined: no counter is built, and the block waits indefinitely for each byte.

Test Plan:
- Read burst:
  - Stimulus: ADDR_W=16; UART bytes 52 01 00 03; flash model returns AA BB CC.
  - Required: FL_ADDR 0x0100, 0x0101, 0x0102, all with FL_FLOW=0; transmitted bytes AA BB CC; BUSY low afterwards.
- Write burst:
  - Stimulus: 57 00 10 02 11 22.
  - Required: flash writes 0x0010=0x11 and 0x0011=0x22; then 0x06 transmitted.
- Bad opcode and bad length:
  - Stimulus: opcode 0x41.
  - Required: 0x15 transmitted immediately, zero FL_TRG pulses.
  - Stimulus: 52 00 00 00 (LEN=0), and separately LEN=MAX_BURST+1.
  - Required: 0x15 in both cases, zero FL_TRG pulses.
- Address wrap:
  - Stimulus: 52 FF FF 02.
  - Required: FL_ADDR 0xFFFF then 0x0000.
- Reset mid-burst:
  - Stimulus: assert RST during FL_WAIT of a read.
  - Required: all outputs 0 in the same cycle; the next frame 52 00 00 01 completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=100):
  - Stimulus: send 57 00 and stall.
  - Required: 0x15 transmitted after 100 cycles.
  - Macro off, same stimulus: no transmission.
